// File: rtl/ev22_alu_sequencer_pkg.sv
// Shared EV22 definitions: ALU function codes, opcodes, FSM states,
// instruction fields and the opcode decode record.
// Optional feature macro used by includers: EV22_ALUSEQ_ADD32_EN.
package ev22_pkg;

    localparam int EV22_REGS = 16;

    typedef logic [3:0] aluc_t;

    // ALU function select codes, shared with the ALU
    localparam aluc_t ALUC_MOVA = 4'h0;
    localparam aluc_t ALUC_MOVB = 4'h1;
    localparam aluc_t ALUC_NOTA = 4'h2;
    localparam aluc_t ALUC_NOTB = 4'h3;
    localparam aluc_t ALUC_ADD  = 4'h4;
    localparam aluc_t ALUC_ADC  = 4'h5;
    localparam aluc_t ALUC_OR   = 4'h6;
    localparam aluc_t ALUC_AND  = 4'h7;
    localparam aluc_t ALUC_CLR  = 4'h8;
    localparam aluc_t ALUC_ONE  = 4'h9;
    localparam aluc_t ALUC_ONES = 4'hA;
    localparam aluc_t ALUC_CLC  = 4'hB;
    localparam aluc_t ALUC_STC  = 4'hC;

    // Opcodes; 0x0-0xC are the ALU codes themselves
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADC   = 4'h5;
    localparam logic [3:0] OP_ONES  = 4'hA;
    localparam logic [3:0] OP_CLC   = 4'hB;
    localparam logic [3:0] OP_STC   = 4'hC;
    localparam logic [3:0] OP_ADD32 = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_EXEC_HI = 2'd2
    } state_e;

    // How the carry flag changes at the end of an execute cycle
    typedef enum logic [1:0] {
        CY_KEEP = 2'd0,
        CY_ALU  = 2'd1,
        CY_CLR  = 2'd2,
        CY_SET  = 2'd3
    } cy_op_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
    } instr_t;

    typedef struct packed {
        aluc_t aluc;
        logic  writes;
        logic  sets_carry;
        logic  clr_carry;
        logic  set_carry;
        logic  is_add32;
        logic  illegal;
    } dec_t;

    // Register index of the high half; wraps modulo EV22_REGS (16)
    function automatic logic [3:0] reg_inc(input logic [3:0] r);
        return r + 4'd1;
    endfunction

endpackage

// File: rtl/ev22_alu_sequencer_if.sv
// Fetch/datapath-facing bus of the EV22 ALU sequencer.
// The master side is fetch + ALU/register file; the slave is the sequencer.
interface ev22_alu_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_cy_out;
    logic [3:0]  aluc;
    logic        alu_cy_in;
    logic [3:0]  ra_sel;
    logic [3:0]  rb_sel;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic        carry;
    logic        done;
    logic        illegal;

    modport master (
        output instr, instr_valid, alu_cy_out,
        input  instr_ready, aluc, alu_cy_in, ra_sel, rb_sel,
               wr_en, wr_sel, carry, done, illegal
    );

    modport slave (
        input  instr, instr_valid, alu_cy_out,
        output instr_ready, aluc, alu_cy_in, ra_sel, rb_sel,
               wr_en, wr_sel, carry, done, illegal
    );
endinterface

// File: rtl/ev22_alu_sequencer_op_decode.sv
// Combinational EV22 opcode decoder.
// EV22_ALUSEQ_ADD32_EN: opcode 0xD decodes as ADD32, otherwise as illegal.
module ev22_op_decode
    import ev22_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    // Opcode to ALU code, write-back, carry behaviour and illegal flag
    always_comb begin
        dec = '0;
        if (opcode <= OP_ONES) begin
            dec.aluc   = opcode;
            dec.writes = 1'b1;
        end
        case (opcode)
            OP_ADD, OP_ADC: dec.sets_carry = 1'b1;
            OP_CLC: begin
                dec.aluc      = ALUC_CLC;
                dec.clr_carry = 1'b1;
            end
            OP_STC: begin
                dec.aluc      = ALUC_STC;
                dec.set_carry = 1'b1;
            end
            OP_ADD32: begin
`ifdef EV22_ALUSEQ_ADD32_EN
                dec.aluc       = ALUC_ADD;
                dec.writes     = 1'b1;
                dec.sets_carry = 1'b1;
                dec.is_add32   = 1'b1;
`else
                dec.illegal    = 1'b1;
`endif
            end
            OP_NOP: ;
            OP_ILL: dec.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ev22_alu_sequencer.sv
// EV22 ALU sequencer: accepts instructions, drives ALU/register-file
// controls from registers, and owns the architectural carry flag.
// EV22_ALUSEQ_ADD32_EN: build the two-pass ADD32 (EXEC_HI state).
module ev22_alu_sequencer
    import ev22_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ev22_alu_sequencer_if.slave  bus
);

    state_e     state_q, state_d;
    instr_t     ir_q, ir_d;
    logic       carry_q, carry_d;
    cy_op_e     cyop_q, cyop_d;
    logic       ready_q, ready_d;
    aluc_t      aluc_q, aluc_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [3:0] wrsel_q, wrsel_d;
    logic       wren_q, wren_d;
    logic       done_q, done_d;
    logic       ill_q, ill_d;
    dec_t       dec;

    // Decode the instruction that will be executing next cycle, so every
    // output can be registered
    ev22_op_decode u_dec (
        .opcode (ir_d.opcode),
        .dec    (dec)
    );

    // Next state and instruction register
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef EV22_ALUSEQ_ADD32_EN
                state_d = dec.is_add32 ? ST_EXEC_HI : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the cycle about to start, keyed on the next state
    always_comb begin
        ready_d = 1'b0;
        aluc_d  = ALUC_MOVA;
        ra_d    = 4'd0;
        rb_d    = 4'd0;
        wrsel_d = 4'd0;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        cyop_d  = CY_KEEP;
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_EXEC: begin
                aluc_d  = dec.aluc;
                ra_d    = ir_d.ra;
                rb_d    = ir_d.rb;
                wrsel_d = ir_d.rd;
                wren_d  = dec.writes;
                done_d  = ~dec.is_add32;
                ill_d   = dec.illegal;
                if (dec.sets_carry)     cyop_d = CY_ALU;
                else if (dec.clr_carry) cyop_d = CY_CLR;
                else if (dec.set_carry) cyop_d = CY_SET;
            end
`ifdef EV22_ALUSEQ_ADD32_EN
            ST_EXEC_HI: begin
                aluc_d  = ALUC_ADC;
                ra_d    = reg_inc(ir_q.ra);
                rb_d    = reg_inc(ir_q.rb);
                wrsel_d = reg_inc(ir_q.rd);
                wren_d  = 1'b1;
                done_d  = 1'b1;
                cyop_d  = CY_ALU;
            end
`endif
            default: ;
        endcase
    end

    // Carry flag update at the edge that ends an execute cycle
    always_comb begin
        carry_d = carry_q;
        if (state_q != ST_IDLE) begin
            case (cyop_q)
                CY_ALU:  carry_d = bus.alu_cy_out;
                CY_CLR:  carry_d = 1'b0;
                CY_SET:  carry_d = 1'b1;
                default: carry_d = carry_q;
            endcase
        end
    end

    // State, instruction, flag and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            carry_q <= 1'b0;
            cyop_q  <= CY_KEEP;
            ready_q <= 1'b1;
            aluc_q  <= ALUC_MOVA;
            ra_q    <= 4'd0;
            rb_q    <= 4'd0;
            wrsel_q <= 4'd0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            cyop_q  <= cyop_d;
            ready_q <= ready_d;
            aluc_q  <= aluc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wrsel_q <= wrsel_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.aluc        = aluc_q;
    assign bus.alu_cy_in   = carry_q;
    assign bus.ra_sel      = ra_q;
    assign bus.rb_sel      = rb_q;
    assign bus.wr_en       = wren_q;
    assign bus.wr_sel      = wrsel_q;
    assign bus.carry       = carry_q;
    assign bus.done        = done_q;
    assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_ev22_alu_sequencer.sv
// Randomized bench for ev22_alu_sequencer against a per-instruction
// reference model. Honors EV22_ALUSEQ_ADD32_EN if defined for the build.
module tb_ev22_alu_sequencer;

`ifdef EV22_ALUSEQ_ADD32_EN
    localparam bit ADD32_EN = 1'b1;
`else
    localparam bit ADD32_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   model_cy = 1'b0;

    ev22_alu_sequencer_if bus ();

    ev22_alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from IDLE and check every cycle it occupies
    task automatic run_instr(input logic [15:0] ins, input bit cy_lo, input bit cy_hi);
        bit [3:0] op, rd, ra, rb, rd1, ra1, rb1;
        bit is32, wr, ill;
        op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
        rd1 = rd + 4'd1; ra1 = ra + 4'd1; rb1 = rb + 4'd1;
        is32 = ADD32_EN && (op == 4'hD);
        wr   = (op <= 4'hA) || is32;
        ill  = (op == 4'hF) || (op == 4'hD && !ADD32_EN);

        chk("ready_idle", 32'(bus.instr_ready), 32'(1));
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
        bus.alu_cy_out  = cy_lo;
        @(negedge clk);
        chk("ready_exec", 32'(bus.instr_ready), 32'(0));
        chk("cy_in_exec", 32'(bus.alu_cy_in), 32'(model_cy));
        if (op <= 4'hC) chk("aluc_exec", 32'(bus.aluc), 32'(op));
        if (is32)       chk("aluc_lo", 32'(bus.aluc), 32'(4));
        chk("wr_en_exec", 32'(bus.wr_en), 32'(wr));
        if (wr) begin
            chk("wr_sel_exec", 32'(bus.wr_sel), 32'(rd));
            chk("ra_sel_exec", 32'(bus.ra_sel), 32'(ra));
            chk("rb_sel_exec", 32'(bus.rb_sel), 32'(rb));
        end
        chk("done_exec", 32'(bus.done), 32'(!is32));
        chk("illegal_exec", 32'(bus.illegal), 32'(ill));
        if (op == 4'h4 || op == 4'h5 || is32) model_cy = cy_lo;
        else if (op == 4'hB)                  model_cy = 1'b0;
        else if (op == 4'hC)                  model_cy = 1'b1;
        step();
        if (is32) begin
            bus.alu_cy_out = cy_hi;
            @(negedge clk);
            chk("aluc_hi", 32'(bus.aluc), 32'(5));
            chk("ra_sel_hi", 32'(bus.ra_sel), 32'(ra1));
            chk("rb_sel_hi", 32'(bus.rb_sel), 32'(rb1));
            chk("wr_sel_hi", 32'(bus.wr_sel), 32'(rd1));
            chk("wr_en_hi", 32'(bus.wr_en), 32'(1));
            chk("done_hi", 32'(bus.done), 32'(1));
            chk("cy_in_hi", 32'(bus.alu_cy_in), 32'(model_cy));
            chk("ready_hi", 32'(bus.instr_ready), 32'(0));
            model_cy = cy_hi;
            step();
        end
        chk("ready_after", 32'(bus.instr_ready), 32'(1));
        chk("carry_after", 32'(bus.carry), 32'(model_cy));
        chk("wr_en_after", 32'(bus.wr_en), 32'(0));
        chk("done_after", 32'(bus.done), 32'(0));
        chk("illegal_after", 32'(bus.illegal), 32'(0));
    endtask

    // Reset while an instruction is executing (in the high pass if hi)
    task automatic reset_mid(input logic [15:0] ins, input bit hi);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        bus.alu_cy_out  = 1'b1;
        if (hi) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_cy = 1'b0;
        chk("rst_ready", 32'(bus.instr_ready), 32'(1));
        chk("rst_wr_en", 32'(bus.wr_en), 32'(0));
        chk("rst_carry", 32'(bus.carry), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        step();
        chk("rst_idle_wr_en", 32'(bus.wr_en), 32'(0));
        chk("rst_idle_carry", 32'(bus.carry), 32'(0));
    endtask

    initial begin
        bus.instr       = 16'h0;
        bus.instr_valid = 1'b0;
        bus.alu_cy_out  = 1'b0;
        rst             = 1'b1;
        step();
        step();
        // Reset values
        chk("reset_ready", 32'(bus.instr_ready), 32'(1));
        chk("reset_aluc", 32'(bus.aluc), 32'(0));
        chk("reset_cy_in", 32'(bus.alu_cy_in), 32'(0));
        chk("reset_sels", 32'({bus.ra_sel, bus.rb_sel, bus.wr_sel}), 32'(0));
        chk("reset_wr_en", 32'(bus.wr_en), 32'(0));
        chk("reset_carry", 32'(bus.carry), 32'(0));
        chk("reset_done", 32'(bus.done), 32'(0));
        chk("reset_illegal", 32'(bus.illegal), 32'(0));
        rst = 1'b0;
        step();

        // ADD r3,r1,r2 carrying out, then STC; ADC r0,r0,r0 clearing carry
        run_instr(16'h4312, 1'b1, 1'b0);
        run_instr(16'hC000, 1'b0, 1'b0);
        run_instr(16'h5000, 1'b0, 1'b0);
        // ADD32 rd=15 ra=4 rb=8 (illegal when the feature is off)
        run_instr(16'hDF48, 1'b1, 1'b0);
        // Illegal opcode with carry set beforehand
        run_instr(16'hC000, 1'b0, 1'b0);
        run_instr(16'hF123, 1'b0, 1'b0);
        run_instr(16'hD321, 1'b0, 1'b1);
        run_instr(16'hE000, 1'b0, 1'b0);

        // Reset mid-instruction (in the high pass when ADD32 exists)
        run_instr(16'hC000, 1'b0, 1'b0);
        reset_mid(16'hD123, ADD32_EN);
        run_instr(16'hC000, 1'b0, 1'b0);
        reset_mid(16'h4123, 1'b0);

        // Reset wins over a simultaneous valid
        rst             = 1'b1;
        bus.instr       = 16'h4567;
        bus.instr_valid = 1'b1;
        step();
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        chk("rst_prio_ready", 32'(bus.instr_ready), 32'(1));
        chk("rst_prio_wr_en", 32'(bus.wr_en), 32'(0));
        step();
        chk("rst_prio_idle", 32'(bus.instr_ready), 32'(1));
        chk("rst_prio_wr_en2", 32'(bus.wr_en), 32'(0));

        // Stream of ORs with valid held high; changes during EXEC ignored
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [15:0] a;
            a = {4'h6, 4'($urandom), 8'($urandom)};
            chk("stream_ready", 32'(bus.instr_ready), 32'(1));
            bus.instr = a;
            step();
            bus.instr = {4'h6, ~a[11:8], ~a[7:0]};
            @(negedge clk);
            chk("stream_ready_exec", 32'(bus.instr_ready), 32'(0));
            chk("stream_aluc", 32'(bus.aluc), 32'(6));
            chk("stream_wr_sel", 32'(bus.wr_sel), 32'(a[11:8]));
            chk("stream_ra_sel", 32'(bus.ra_sel), 32'(a[7:4]));
            step();
        end
        bus.instr_valid = 1'b0;
        chk("stream_end_ready", 32'(bus.instr_ready), 32'(1));

        // Random instruction mix
        repeat (200) begin
            run_instr(16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ev22_alu_sequencer.md
# ev22_alu_sequencer

Control-side counterpart of the EV22 16-bit ALU. Accepts decoded-format instruction words over a valid/ready handshake and drives the ALU function select (`aluc`), carry input and register-file read/write controls. Owns the architectural carry flag, registering the ALU carry-out. Optionally sequences double-word (32-bit) adds as two ALU passes. Sits between the instruction fetch stage and the ALU/register-file datapath.

## Interface
- `EV22_REGS`, 16: register-file depth. Register indices are 4 bits and wrap modulo 16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instr` input 16: instruction; [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb.
- `instr_valid` input 1: `instr` is valid.
- `instr_ready` output 1: sequencer accepts `instr` this cycle.
- `alu_cy_out` input 1: ALU carry-out, sampled in execute cycles.
- `aluc` output 4: ALU function select.
- `alu_cy_in` output 1: ALU carry-in; always equals the carry flag.
- `ra_sel` output 4: register-file read port A index (ALU `a`).
- `rb_sel` output 4: register-file read port B index (ALU `b`).
- `wr_en` output 1: register-file write enable; write occurs at the clock edge ending the cycle.
- `wr_sel` output 4: register-file write index.
- `carry` output 1: architectural carry flag.
- `done` output 1: one-cycle pulse in the final execute cycle of each instruction.
- `illegal` output 1: one-cycle pulse when an illegal opcode is accepted.

## Operation
- Opcodes 0x0–0xC map one-to-one onto `aluc`: MOVA 0, MOVB 1, NOTA 2, NOTB 3, ADD 4, ADC 5, OR 6, AND 7, CLR 8, ONE 9, ONES A, CLC B, STC C.
- 0xD: ADD32 when `EV22_ALUSEQ_ADD32_EN` is defined; otherwise illegal. 0xE: NOP. 0xF: illegal.
- FSM states: IDLE, EXEC, EXEC_HI.
- IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` into the instruction register and go to EXEC.
- EXEC, opcodes 0x0–0xA: `wr_en`=1 and `wr_sel`=rd.
- EXEC, opcodes B, C, E, illegal: `wr_en`=0.
- EXEC, ADD32: `aluc`=ADD with ra/rb/rd low halves; go to EXEC_HI. Otherwise `done`=1 and return to IDLE.
- EXEC_HI: `aluc`=ADC; `ra_sel`, `rb_sel` and `wr_sel` are each the latched index +1 mod 16; `wr_en`=1; `done`=1; return to IDLE.
- Carry flag updates at the edge ending an execute cycle, and only for these operations:
  - ADD, ADC and both ADD32 passes: flag ← `alu_cy_out`.
  - CLC: flag ← 0.
  - STC: flag ← 1.
  - All other opcodes leave the flag unchanged.
- Illegal opcode: `illegal` pulses in the EXEC cycle; nothing is written; carry is unchanged.

## Timing
- Reset values: state IDLE, `instr_ready`=1, `aluc`=0, `alu_cy_in`=0, `ra_sel`/`rb_sel`/`wr_sel`=0, `wr_en`=0, `carry`=0, `done`=0, `illegal`=0.
- Outputs decode from the state and instruction registers only; there is no combinational path from `instr` or `instr_valid` to any output.
- Latency:
  - Accept at edge N, then EXEC during cycle N+1, then `instr_ready` high again in cycle N+2. Throughput is one instruction per 2 cycles.
  - ADD32 is one cycle longer (EXEC, then EXEC_HI).
- `instr_ready` is 0 in EXEC and EXEC_HI; `instr` is ignored while `instr_ready`=0.
- Back-to-back dependency: an ADC immediately after an ADD sees the updated flag on `alu_cy_in`, because the flag is registered before the next EXEC.
- `rst` asserted in any state: the FSM goes to IDLE at that edge and an in-flight ADD32 high pass is abandoned. `wr_en` is 0 in the cycle after reset.
- `rst` takes priority over a simultaneous `instr_valid`.

## Configuration
- `EV22_ALUSEQ_ADD32_EN` defined: opcode 0xD performs the two-pass ADD32, and the EXEC_HI state exists.
- Macro undefined: 0xD pulses `illegal`, performs no write and leaves carry unchanged; EXEC_HI is not built.

## Structure
- Package `ev22_pkg` holds:
  - `aluc` code constants, shared with the ALU.
  - Opcode constants.
  - State enum typedef.
  - Instruction field typedef.
- Natural sub-module: `ev22_op_decode`, a combinational opcode-to-{aluc, writes, sets_carry, is_add32, illegal} decoder. The FSM and flag register stay in the top level.

## Test plan
- Reset, then ADD r3,r1,r2 with `alu_cy_out`=1:
  - Cycle 1: `aluc`=4, `ra_sel`=1, `rb_sel`=2, `wr_en`=1, `wr_sel`=3, `done`=1.
  - Afterwards `carry`=1.
- STC, then ADC r0,r0,r0: ADC cycle drives `aluc`=5 and `alu_cy_in`=1. With `alu_cy_out`=0, `carry` becomes 0.
- ADD32 rd=15, ra=4, rb=8 (macro on):
  - EXEC: `aluc`=4, `wr_sel`=15.
  - EXEC_HI: `aluc`=5, `ra_sel`=5, `rb_sel`=9, `wr_sel`=0, `done`=1 only in EXEC_HI.
- Opcode 0xF, and 0xD with macro off: `illegal`=1 for one cycle, `wr_en`=0, `carry` unchanged.
- `rst` during EXEC_HI: next cycle is IDLE, `wr_en`=0, `carry`=0, `instr_ready`=1.
- `instr_valid` held high with a stream of ORs: one accept every 2 cycles; `instr` changes while `instr_ready`=0 are ignored.
